// File: rtl/mult_pkg.sv
// Shared constants and types for the multiplier result stage.
package mult_pkg;

  localparam int DEF_PROD_W = 32;
  localparam int DEF_OUT_W  = 16;

  localparam logic [1:0] MODE_LOW  = 2'b00;
  localparam logic [1:0] MODE_HIGH = 2'b01;
  localparam logic [1:0] MODE_SAT  = 2'b10;
  localparam logic [1:0] MODE_FULL = 2'b11;

  // 16-bit saturation limits, sign-extended by the formatter.
  localparam logic [15:0] SAT_MAX = 16'h7FFF;
  localparam logic [15:0] SAT_MIN = 16'h8000;

  // Buffer occupancy, encoded as the entry count.
  typedef enum logic [1:0] {
    CNT_EMPTY = 2'd0,
    CNT_ONE   = 2'd1,
    CNT_FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/result_formatter.sv
// Combinational formatter: turns a signed product into the stored result
// and its flags according to the transaction mode.
module result_formatter
  import mult_pkg::*;
#(
  parameter int PROD_W = DEF_PROD_W,
  parameter int OUT_W  = DEF_OUT_W
) (
  input  logic [PROD_W-1:0] in_prod,
  input  logic [1:0]        in_mode,
  output logic [PROD_W-1:0] result,
  output logic              zero,
  output logic              neg,
  output logic              ovf
);

  logic              fits_s;
  logic [PROD_W-1:0] low_ext_s;
  logic [PROD_W-1:0] high_ext_s;

  // The product fits the narrow datapath when its upper bits are pure sign copies.
  always_comb begin
    fits_s     = (&in_prod[PROD_W-1:OUT_W-1]) | ~(|in_prod[PROD_W-1:OUT_W-1]);
    low_ext_s  = {{(PROD_W-OUT_W){in_prod[OUT_W-1]}}, in_prod[OUT_W-1:0]};
    high_ext_s = {{(PROD_W-OUT_W){in_prod[PROD_W-1]}}, in_prod[PROD_W-1:PROD_W-OUT_W]};
  end

  // Mode select plus flags; flags describe the formatted result, not the raw product.
  always_comb begin
    result = {PROD_W{1'b0}};
    ovf    = 1'b0;
    case (in_mode)
      MODE_LOW: begin
        result = low_ext_s;
        ovf    = ~fits_s;
      end
      MODE_HIGH: begin
        result = high_ext_s;
        ovf    = 1'b0;
      end
      MODE_SAT: begin
        if (fits_s) begin
          result = low_ext_s;
          ovf    = 1'b0;
        end else if (in_prod[PROD_W-1]) begin
          result = {{(PROD_W-OUT_W){SAT_MIN[OUT_W-1]}}, SAT_MIN};
          ovf    = 1'b1;
        end else begin
          result = {{(PROD_W-OUT_W){SAT_MAX[OUT_W-1]}}, SAT_MAX};
          ovf    = 1'b1;
        end
      end
      MODE_FULL: begin
        result = in_prod;
        ovf    = 1'b0;
      end
      default: begin
        result = in_prod;
        ovf    = 1'b0;
      end
    endcase
    zero = (result == {PROD_W{1'b0}});
    neg  = result[PROD_W-1];
  end

endmodule

// File: rtl/mult_result_stage.sv
// Multiplier result stage: formats each accepted product and buffers it in a
// 2-entry FIFO so writeback back-pressure never reaches the producer combinationally.
module mult_result_stage
  import mult_pkg::*;
#(
  parameter int PROD_W = DEF_PROD_W,
  parameter int OUT_W  = DEF_OUT_W,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic [1:0]        in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] out_result,
  output logic              out_zero,
  output logic              out_neg,
  output logic              out_ovf
);

  occ_e              count_r;
  occ_e              count_nxt_s;
  logic              in_ready_r;
  logic              out_valid_r;
  logic              wr_ptr_r;
  logic              rd_ptr_r;
  logic              push_s;
  logic              pop_s;

  logic [PROD_W-1:0] fmt_result_s;
  logic              fmt_zero_s;
  logic              fmt_neg_s;
  logic              fmt_ovf_s;

  logic [PROD_W-1:0] mem_result_r [DEPTH];
  logic              mem_zero_r   [DEPTH];
  logic              mem_neg_r    [DEPTH];
  logic              mem_ovf_r    [DEPTH];

  result_formatter #(
    .PROD_W (PROD_W),
    .OUT_W  (OUT_W)
  ) u_fmt (
    .in_prod (in_prod),
    .in_mode (in_mode),
    .result  (fmt_result_s),
    .zero    (fmt_zero_s),
    .neg     (fmt_neg_s),
    .ovf     (fmt_ovf_s)
  );

  // Handshake qualifiers use only registered ready/valid.
  always_comb begin
    push_s = in_valid & in_ready_r;
    pop_s  = out_valid_r & out_ready;
  end

  // Occupancy next state; a simultaneous push and pop in ONE stays in ONE.
  always_comb begin
    count_nxt_s = count_r;
    case (count_r)
      CNT_EMPTY: begin
        if (push_s) count_nxt_s = CNT_ONE;
        else        count_nxt_s = CNT_EMPTY;
      end
      CNT_ONE: begin
        if (push_s && !pop_s)      count_nxt_s = CNT_FULL;
        else if (pop_s && !push_s) count_nxt_s = CNT_EMPTY;
        else                       count_nxt_s = CNT_ONE;
      end
      CNT_FULL: begin
        if (pop_s) count_nxt_s = CNT_ONE;
        else       count_nxt_s = CNT_FULL;
      end
      default: count_nxt_s = CNT_EMPTY;
    endcase
  end

  // Count, pointers and the registered valid/ready decoded from the next count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r     <= CNT_EMPTY;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
      wr_ptr_r    <= 1'b0;
      rd_ptr_r    <= 1'b0;
    end else begin
      count_r     <= count_nxt_s;
      out_valid_r <= (count_nxt_s != CNT_EMPTY);
      in_ready_r  <= (count_nxt_s != CNT_FULL);
      if (push_s) wr_ptr_r <= ~wr_ptr_r;
      if (pop_s)  rd_ptr_r <= ~rd_ptr_r;
    end
  end

  // Entry storage; written only on an accepted push so idle inputs never land.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_result_r[i] <= {PROD_W{1'b0}};
        mem_zero_r[i]   <= 1'b0;
        mem_neg_r[i]    <= 1'b0;
        mem_ovf_r[i]    <= 1'b0;
      end
    end else if (push_s) begin
      mem_result_r[wr_ptr_r] <= fmt_result_s;
      mem_zero_r[wr_ptr_r]   <= fmt_zero_s;
      mem_neg_r[wr_ptr_r]    <= fmt_neg_s;
      mem_ovf_r[wr_ptr_r]    <= fmt_ovf_s;
    end
  end

  assign in_ready   = in_ready_r;
  assign out_valid  = out_valid_r;
  assign out_result = mem_result_r[rd_ptr_r];
  assign out_zero   = mem_zero_r[rd_ptr_r];
  assign out_neg    = mem_neg_r[rd_ptr_r];
  assign out_ovf    = mem_ovf_r[rd_ptr_r];

endmodule

// File: tb/tb_mult_result_stage.sv
// Bench for mult_result_stage: queue-based reference model plus directed
// literal checks, followed by randomized traffic.
module tb_mult_result_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_prod;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic        out_neg;
  logic        out_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] r;
    logic        z;
    logic        n;
    logic        o;
  } exp_t;

  exp_t q[$];

  mult_result_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_prod    (in_prod),
    .in_mode    (in_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_zero   (out_zero),
    .out_neg    (out_neg),
    .out_ovf    (out_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference formatting from signed arithmetic on the product value.
  function automatic exp_t fmt(input logic [31:0] p, input logic [1:0] m);
    exp_t   e;
    logic [15:0] lo;
    logic [15:0] hi;
    longint v;
    longint vlo;
    longint vhi;
    lo  = p[15:0];
    hi  = p[31:16];
    v   = longint'($signed(p));
    vlo = longint'($signed(lo));
    vhi = longint'($signed(hi));
    e.o = 1'b0;
    case (m)
      2'd0: begin e.r = 32'(vlo); e.o = (v > 32767) || (v < -32768); end
      2'd1: begin e.r = 32'(vhi); end
      2'd2: begin
        if (v > 32767)       begin e.r = 32'h0000_7FFF; e.o = 1'b1; end
        else if (v < -32768) begin e.r = 32'hFFFF_8000; e.o = 1'b1; end
        else                 begin e.r = 32'(v); end
      end
      default: e.r = p;
    endcase
    e.z = (e.r == 32'd0);
    e.n = e.r[31];
    return e;
  endfunction

  // Model update: acceptance decided from model occupancy, never from DUT ready.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      bit do_push;
      bit do_pop;
      do_pop  = (q.size() > 0) && out_ready;
      do_push = in_valid && (q.size() < 2);
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(fmt(in_prod, in_mode));
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
      chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
      if (q.size() > 0) begin
        chk("out_result", out_result, q[0].r);
        chk("out_zero", 32'(out_zero), 32'(q[0].z));
        chk("out_neg", 32'(out_neg), 32'(q[0].n));
        chk("out_ovf", 32'(out_ovf), 32'(q[0].o));
      end
    end
  end

  // Single directed push into an empty stage with a hand-computed expectation.
  task automatic push_one(input logic [31:0] p, input logic [1:0] m, input logic [31:0] er,
                          input logic ez, input logic en, input logic eo, input string name);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_prod   = p;
    in_mode   = m;
    @(negedge clk);
    in_valid = 1'b0;
    chk({name, "_valid"}, 32'(out_valid), 32'd1);
    chk({name, "_res"}, out_result, er);
    chk({name, "_zero"}, 32'(out_zero), 32'(ez));
    chk({name, "_neg"}, 32'(out_neg), 32'(en));
    chk({name, "_ovf"}, 32'(out_ovf), 32'(eo));
  endtask

  initial begin
    exp_t e;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_prod   = 32'd0;
    in_mode   = 2'd0;
    out_ready = 1'b0;

    // Pin the model itself against hand-computed values.
    e = fmt(32'hFFFF_FFF1, 2'd2); chk("model_sat_small", e.r, 32'hFFFF_FFF1); chk("model_sat_small_ovf", 32'(e.o), 32'd0);
    e = fmt(32'h0001_0000, 2'd2); chk("model_sat_pos", e.r, 32'h0000_7FFF); chk("model_sat_pos_ovf", 32'(e.o), 32'd1);
    e = fmt(32'h1234_5678, 2'd1); chk("model_high", e.r, 32'h0000_1234);
    e = fmt(32'h0000_8000, 2'd0); chk("model_low_neg", e.r, 32'hFFFF_8000); chk("model_low_ovf", 32'(e.o), 32'd1);

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", out_result, 32'd0);
    chk("rst_flags", {29'd0, out_zero, out_neg, out_ovf}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    chk("idle_out_valid", 32'(out_valid), 32'd0);
    chk("idle_result", out_result, 32'd0);

    // Directed formatting cases.
    push_one(32'hFFFF_FFF1, 2'd2, 32'hFFFF_FFF1, 1'b0, 1'b1, 1'b0, "sat_fit");
    push_one(32'h0001_0000, 2'd2, 32'h0000_7FFF, 1'b0, 1'b0, 1'b1, "sat_pos");
    push_one(32'hC000_0000, 2'd2, 32'hFFFF_8000, 1'b0, 1'b1, 1'b1, "sat_neg");
    push_one(32'h1234_5678, 2'd1, 32'h0000_1234, 1'b0, 1'b0, 1'b0, "high");
    push_one(32'h1234_5678, 2'd0, 32'h0000_5678, 1'b0, 1'b0, 1'b1, "low");
    push_one(32'h0000_8000, 2'd0, 32'hFFFF_8000, 1'b0, 1'b1, 1'b1, "low_neg");
    push_one(32'h0000_0000, 2'd3, 32'h0000_0000, 1'b1, 1'b0, 1'b0, "full_zero");
    @(negedge clk);

    // Back-pressure: A, B, C back to back with the consumer stalled.
    out_ready = 1'b0; in_valid = 1'b1; in_mode = 2'd3; in_prod = 32'hAAAA_0001;
    @(negedge clk); in_prod = 32'hBBBB_0002;
    @(negedge clk); chk("bp_ready_low", 32'(in_ready), 32'd0); in_prod = 32'hCCCC_0003;
    @(negedge clk); chk("bp_ready_held", 32'(in_ready), 32'd0); chk("bp_a", out_result, 32'hAAAA_0001);
    out_ready = 1'b1;
    @(negedge clk); chk("bp_b", out_result, 32'hBBBB_0002); chk("bp_ready_back", 32'(in_ready), 32'd1);
    @(negedge clk); in_valid = 1'b0; chk("bp_c", out_result, 32'hCCCC_0003);
    @(negedge clk); chk("bp_drained", 32'(out_valid), 32'd0);

    // Streaming: push and pop every cycle, occupancy stays at one.
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_prod = $urandom;
      in_mode = 2'($urandom_range(0, 3));
      @(negedge clk);
      chk("stream_valid", 32'(out_valid), 32'd1);
      chk("stream_ready", 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0;
    @(negedge clk);

    // Stability with full occupancy and a stalled consumer.
    out_ready = 1'b0; in_valid = 1'b1; in_mode = 2'd2; in_prod = 32'h0012_3456;
    @(negedge clk); in_prod = 32'hFFFF_FFFE; in_mode = 2'd3;
    @(negedge clk); in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_result", out_result, 32'h0000_7FFF);
      chk("hold_flags", {29'd0, out_zero, out_neg, out_ovf}, 32'd1);
      chk("hold_full", 32'(in_ready), 32'd0);
    end

    // Asynchronous reset while two results are buffered.
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", 32'(out_valid), 32'd0);
    chk("post_rst_ready", 32'(in_ready), 32'd1);
    chk("post_rst_result", out_result, 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      in_mode   = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) in_prod = 32'($signed(16'($urandom)));
      else                           in_prod = $urandom;
      @(negedge clk);
    end

    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("final_drained", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
